// File: rtl/spi_flash_reader_if.sv
// Host-side request / byte-stream bundle for spi_flash_reader.
interface spi_flash_reader_if;
  logic        start;
  logic [23:0] start_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  modport master (
    output start, start_addr, length, byte_ready,
    input  busy, done, byte_out, byte_valid
  );

  modport slave (
    input  start, start_addr, length, byte_ready,
    output busy, done, byte_out, byte_valid
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master issuing READ (0x03) + 24-bit address, streaming the
// returned bytes over a valid/ready interface with SCLK stalled on backpressure.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic              clock_12mhz,
  input  logic              reset,
  spi_flash_reader_if.slave bus,
  output logic              flash_cs,
  output logic              flash_sclk,
  output logic              flash_mosi,
  input  logic              flash_miso
);
  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [7:0]    CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SHIFT_OUT, SHIFT_IN, HAND, CS_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic [31:0]   sr_q, sr_d;
  logic [5:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          xfer_q, xfer_d;
  logic [15:0]   remain_q, remain_d;
  logic          div_zero;
  logic          take;

  assign div_zero = (div_q == '0);
  assign take     = valid_q && bus.byte_ready;

  assign flash_cs       = cs_q;
  assign flash_sclk     = sclk_q;
  assign flash_mosi     = mosi_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = valid_q;

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      sr_q     <= '0;
      bitcnt_q <= '0;
      rx_q     <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      xfer_q   <= 1'b0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      xfer_q   <= xfer_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    mosi_d   = mosi_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    byte_d   = byte_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    xfer_d   = xfer_q;
    remain_d = remain_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != 16'd0) begin
            state_d  = CS_SETUP;
            busy_d   = 1'b1;
            cs_d     = 1'b0;
            sr_d     = {CMD_READ, bus.start_addr};
            mosi_d   = CMD_READ[7];
            remain_d = bus.length;
            div_d    = DIV_LAST;
            bitcnt_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      CS_SETUP: begin
        if (div_zero) begin
          sclk_d  = 1'b1;
          div_d   = DIV_LAST;
          state_d = SHIFT_OUT;
        end else begin
          div_d = div_q - DW'(1);
        end
      end
      SHIFT_OUT: begin
        if (!div_zero) begin
          div_d = div_q - DW'(1);
        end else begin
          div_d = DIV_LAST;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bitcnt_q == 6'd31) begin
              state_d  = SHIFT_IN;
              mosi_d   = 1'b0;
              bitcnt_d = '0;
            end else begin
              mosi_d   = sr_q[30];
              sr_d     = {sr_q[30:0], 1'b0};
              bitcnt_d = bitcnt_q + 6'd1;
            end
          end
        end
      end
      SHIFT_IN: begin
        if (!div_zero) begin
          div_d = div_q - DW'(1);
        end else begin
          div_d = DIV_LAST;
          if (!sclk_q) begin
            sclk_d   = 1'b1;
            rx_d     = {rx_q[6:0], flash_miso};
            bitcnt_d = bitcnt_q + 6'd1;
          end else begin
            sclk_d = 1'b0;
            if (bitcnt_q == 6'd8) begin
              byte_d   = rx_q;
              valid_d  = 1'b1;
              bitcnt_d = '0;
              state_d  = HAND;
            end
          end
        end
      end
      HAND: begin
        if (!div_zero) div_d = div_q - DW'(1);
        if (take) begin
          valid_d  = 1'b0;
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_d = CS_HOLD;
            cs_d    = 1'b1;
            div_d   = DIV_LAST;
          end else begin
            xfer_d = 1'b1;
          end
        end
        // Next rising edge waits for both the low-phase timer and the transfer.
        if ((xfer_q || (take && remain_q != 16'd1)) && div_zero) begin
          state_d  = SHIFT_IN;
          sclk_d   = 1'b1;
          div_d    = DIV_LAST;
          xfer_d   = 1'b0;
          rx_d     = {rx_q[6:0], flash_miso};
          bitcnt_d = 6'd1;
        end
      end
      CS_HOLD: begin
        if (div_zero) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          div_d = div_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
